// File: rtl/fsm_cond_pkg.sv
// Shared types and defaults for the input-conditioning block: debounce state
// encoding and the default debounce length.
package fsm_cond_pkg;

  typedef enum logic [1:0] {
    LO     = 2'd0,
    CHK_HI = 2'd1,
    HI     = 2'd2,
    CHK_LO = 2'd3
  } db_state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 4;

endpackage

// File: rtl/fsm_debounce.sv
// One input channel: 2-flop synchronizer followed by a debounce FSM whose level
// flips only after DEBOUNCE_CYCLES consecutive disagreeing synchronized samples.
module fsm_debounce
  import fsm_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  // The CHK_* entry edge counts as the first disagreeing sample, so the last
  // counter value before committing is N-2.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

  logic             sync1;
  logic             sync2;
  db_state_t        state;
  db_state_t        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      state <= LO;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      LO: begin
        if (sync2) begin
          state_nxt = CHK_HI;
          cnt_nxt   = '0;
        end
      end
      CHK_HI: begin
        if (!sync2) begin
          state_nxt = LO;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HI;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      HI: begin
        if (!sync2) begin
          state_nxt = CHK_LO;
          cnt_nxt   = '0;
        end
      end
      CHK_LO: begin
        if (sync2) begin
          state_nxt = HI;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = LO;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = LO;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign level = (state == HI) || (state == CHK_LO);

endmodule

// File: rtl/fsm_input_cond.sv
// Debounced go/jmp conditioning for the downstream sequence FSM.
// Define FSM_COND_JMP_PULSE_EN to turn jmp into a one-cycle pulse per rising level.
module fsm_input_cond
  import fsm_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic go_raw,
  input  logic jmp_raw,
  output logic go,
  output logic jmp
);

  logic go_lvl;
  logic jmp_lvl;

  fsm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_go_db (
    .clk   (clk),
    .rst   (rst),
    .raw   (go_raw),
    .level (go_lvl)
  );

  fsm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_jmp_db (
    .clk   (clk),
    .rst   (rst),
    .raw   (jmp_raw),
    .level (jmp_lvl)
  );

  assign go = go_lvl;

`ifdef FSM_COND_JMP_PULSE_EN
  logic jmp_lvl_q;

  always_ff @(posedge clk) begin
    if (rst) jmp_lvl_q <= 1'b0;
    else     jmp_lvl_q <= jmp_lvl;
  end

  // Both terms are flop outputs, so the pulse lasts exactly the first HI cycle.
  assign jmp = jmp_lvl & ~jmp_lvl_q;
`else
  assign jmp = jmp_lvl;
`endif

endmodule

// File: tb/tb_fsm_input_cond.sv
// Vector-table bench for fsm_input_cond: an N=4 instance and an N=2 instance,
// expectations queued on drive and compared one edge later.
module tb_fsm_input_cond;
  import fsm_cond_pkg::*;

`ifdef FSM_COND_JMP_PULSE_EN
  localparam bit PULSE = 1'b1;
`else
  localparam bit PULSE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic go_raw = 1'b0, jmp_raw = 1'b0, go, jmp;
  logic go_raw2 = 1'b0, jmp_raw2 = 1'b0, go2, jmp2;

  always #5 clk = ~clk;

  fsm_input_cond dut (
    .clk(clk), .rst(rst), .go_raw(go_raw), .jmp_raw(jmp_raw), .go(go), .jmp(jmp)
  );

  fsm_input_cond #(.DEBOUNCE_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .go_raw(go_raw2), .jmp_raw(jmp_raw2), .go(go2), .jmp(jmp2)
  );

  typedef struct {
    logic  r, g, j, g2, j2;
    logic  eg, ej, eg2, ej2;
    bit    lo;
    string tag;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input logic r, g, j, g2, j2, eg, ej, eg2, ej2,
                     input bit lo, input string tag);
    vec_t v;
    v.r = r; v.g = g; v.j = j; v.g2 = g2; v.j2 = j2;
    v.eg = eg; v.ej = ej; v.eg2 = eg2; v.ej2 = ej2;
    v.lo = lo; v.tag = tag;
    vecs.push_back(v);
  endtask

  function automatic logic jx(input logic lvl_on, input logic pulse_on);
    return PULSE ? pulse_on : lvl_on;
  endfunction

  task automatic chk(input string tag, input string sig, input logic act, input logic exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s %s: got %b expected %b", tag, sig, act, exp);
    end
  endtask

  task automatic build();
    // Reset with both raws low, then idle.
    for (int i = 0; i < 2; i++) add(1, 0, 0, 0, 0, 0, 0, 0, 0, i == 1, "rst");
    for (int i = 0; i < 2; i++) add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1, "idle");
    // go rises at e+5 and falls at e+5 of the low run.
    for (int i = 0; i < 10; i++) add(0, 1, 0, 0, 0, i >= 5, 0, 0, 0, 0, "go_rise");
    for (int i = 0; i < 10; i++) add(0, 0, 0, 0, 0, i < 5, 0, 0, 0, i == 9, "go_fall");
    // N-1 cycle glitch: no change, FSM back in LO.
    for (int i = 0; i < 10; i++) add(0, i < 3, 0, 0, 0, 0, 0, 0, 0, i == 9, "go_glitch");
    // Exactly N high cycles is enough to flip.
    for (int i = 0; i < 10; i++)
      add(0, i < 4, 0, 0, 0, (i >= 5) && (i <= 8), 0, 0, 0, i == 9, "go_n_run");
    // jmp high 8 then low 10.
    for (int i = 0; i < 18; i++)
      add(0, 0, i < 8, 0, 0, 0, jx((i >= 5) && (i < 13), i == 5), 0, 0, i == 17, "jmp_run");
    // Both raws held high, reset pulsed mid-count.
    for (int i = 0; i < 12; i++)
      add(i == 3, 1, 1, 0, 0, i >= 9, jx(i >= 9, i == 9), 0, 0, 0, "rst_mid");
    for (int i = 0; i < 8; i++)
      add(0, 0, 0, 0, 0, i < 5, jx(i < 5, 1'b0), 0, 0, i == 7, "rst_mid_fall");
    // N=2 instance: both channels rise together at e+3, fall at e+3 of low run.
    for (int i = 0; i < 12; i++)
      add(0, 0, 0, i < 5, i < 5, 0, 0, (i >= 3) && (i < 8),
          jx((i >= 3) && (i < 8), i == 3), 0, "n2_both");
  endtask

  initial begin
    vec_t v;
    vec_t e;
    build();
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(negedge clk);
      rst = v.r; go_raw = v.g; jmp_raw = v.j; go_raw2 = v.g2; jmp_raw2 = v.j2;
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_vec++;
      chk(e.tag, "go", go, e.eg);
      chk(e.tag, "jmp", jmp, e.ej);
      chk(e.tag, "go2", go2, e.eg2);
      chk(e.tag, "jmp2", jmp2, e.ej2);
      if (e.lo) begin
        chk(e.tag, "go_state_lo", dut.u_go_db.state == LO, 1'b1);
        chk(e.tag, "jmp_state_lo", dut.u_jmp_db.state == LO, 1'b1);
      end
    end
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fsm_input_cond.md
FSM_INPUT_COND -- requirements
Module: fsm_input_cond

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, consecutive synchronized cycles a raw input must hold a new level before the output follows; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high, sampled on the rising edge of clk.
REQ-004 go_raw  input  1  asynchronous raw "go" button/switch level.
REQ-005 jmp_raw  input  1  asynchronous raw "jmp" button/switch level.
REQ-006 go  output  1  debounced go level; drives go of the downstream sequence FSM.
REQ-007 jmp  output  1  debounced jmp (level or pulse per REQ-021); drives jmp of the downstream sequence FSM.

Function
REQ-008 Each raw input SHALL pass through its own 2-flop synchronizer (sync1, sync2); only sync2 feeds debounce logic.
REQ-009 Each channel SHALL hold a debounce FSM with states LO, CHK_HI, HI, CHK_LO; debounced level = 1 in HI and CHK_LO, 0 in LO and CHK_HI.
REQ-010 LO: sync2=1 -> CHK_HI with counter cleared to 0; else stay.
REQ-011 CHK_HI: sync2=0 -> LO, counter cleared; sync2=1 and counter=DEBOUNCE_CYCLES-2 -> HI, counter cleared; else counter+1.
REQ-012 HI/CHK_LO SHALL mirror REQ-010/011 with levels inverted (HI -> CHK_LO on sync2=0; CHK_LO -> HI on sync2=1; CHK_LO -> LO after count).
REQ-013 Net rule: debounced level flips at the Nth consecutive clock edge at which sync2 differs from it (N=DEBOUNCE_CYCLES); any disagreement run shorter than N SHALL leave the level unchanged.
REQ-014 Latency: raw level change first sampled into sync1 at edge e SHALL reach the debounced level at edge e+1+N (edge e+5 for N=4), provided raw stays stable.
REQ-015 Counter width SHALL be $clog2(DEBOUNCE_CYCLES); counter never exceeds DEBOUNCE_CYCLES-2 and never wraps.
REQ-016 go SHALL equal the go channel's debounced level (registered, no combinational path from raw inputs).
REQ-017 Channels SHALL be independent; simultaneous changes on both raw inputs SHALL each follow REQ-013 with no interaction.

Reset
REQ-018 While rst=1 at a clock edge: sync flops 0, both FSMs LO, counters 0, go=0, jmp=0, pulse-edge register 0.
REQ-019 Reset asserted mid-CHK_* SHALL discard partial count; after release a held-high raw input SHALL require the full REQ-014 latency again.
REQ-020 Raw input high at reset release SHALL appear on the output as a normal rising transition (and produce one jmp pulse under REQ-021).

Configuration
REQ-021 Macro FSM_COND_JMP_PULSE_EN defined: jmp SHALL be a single-cycle registered pulse, high for exactly one cycle after each 0->1 transition of the jmp debounced level; undefined: jmp SHALL equal the jmp debounced level.
REQ-022 go SHALL be a level in both configurations.

Structure
REQ-023 Package fsm_cond_pkg SHALL hold the debounce state typedef (LO, CHK_HI, HI, CHK_LO, 2-bit encoding) and the DEBOUNCE_CYCLES default constant.
REQ-024 One sub-module fsm_debounce (synchronizer + FSM + counter, parameterized by DEBOUNCE_CYCLES) SHALL be instantiated twice; pulse logic lives in the top.

Verification
REQ-025 rst=1 two cycles, raws 0 -> go=0, jmp=0, both FSMs LO.
REQ-026 N=4, go_raw 0->1 held 10 cycles -> go rises at edge e+5, stays 1.
REQ-027 N=4, go_raw high 3 cycles then low (glitch) -> go stays 0 throughout, FSM returns to LO.
REQ-028 jmp_raw high 8 cycles then low 8 cycles -> level build: jmp 1 from e+5 for 8 cycles; pulse build: jmp 1 for exactly one cycle at e+5.
REQ-029 go_raw held high, rst pulsed at edge e+3 -> go stays 0, rises 5 edges after reset release sampling.
REQ-030 go_raw and jmp_raw rise same cycle, N=2 -> go and jmp both rise at edge e+3 together.
